gray_ptr_counter: RTL and testbench

Parametrised, fully registered Gray-code pointer counter for the asynchronous FIFO's CDC path. It keeps a binary pointer and its Gray encoding in lock-step registers, so the Gray value handed to the other clock domain is glitch-free and changes by exactly one bit per increment. It also registers a binary decode of the synchronised remote Gray pointer for local full/empty arithmetic. One instance sits in each FIFO clock domain: one for the write pointer, one for the read pointer.

---
 rtl/gray_ptr_counter.sv | 109 ++++++++++
 tb/tb_gray_ptr_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter
//
// Registered Gray-code pointer counter for one clock domain of an asynchronous
// FIFO. A binary pointer and its Gray encoding are kept in lock-step registers.
// The Gray register is loaded from the Gray encoding of the *next* binary value,
// so o_gray never depends combinationally on the o_bin flops and is glitch-free
// when it crosses into the other domain. The block also registers a binary
// decode of the already-synchronised remote Gray pointer for full/empty maths.
//
// Parameters:
//   WIDTH - pointer width in bits (>= 2): FIFO address bits plus one wrap bit
//   INIT  - binary reset value of the pointer (< 2**WIDTH)
//
// Ports:
//   i_clk         - domain clock, all state updates on the rising edge
//   i_rst         - synchronous active-high reset
//   i_inc         - advance the pointer by one this cycle
//   i_load        - load the pointer from i_load_bin (wins over i_inc)
//   i_load_bin    - binary load value
//   i_gray_remote - remote Gray pointer, already synchronised into this domain
//   o_bin         - registered binary pointer
//   o_gray        - registered Gray pointer, always gray(o_bin)
//   o_wrap        - one-cycle pulse when the pointer wraps from all-ones to 0
//   o_remote_bin  - registered binary decode of i_gray_remote

module gray_ptr_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned INIT  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_bin,
    input  logic [WIDTH-1:0] i_gray_remote,
    output logic [WIDTH-1:0] o_bin,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_remote_bin
);

    localparam logic [WIDTH-1:0] InitBin  = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] IncStep  = WIDTH'(1);

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Gray to binary: prefix XOR evaluated from the MSB downwards.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [WIDTH-1:0] InitGray = bin2gray(InitBin);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] remote_bin_q, remote_bin_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;

        if (i_load) begin
            bin_d = i_load_bin;
        end else if (i_inc) begin
            bin_d  = bin_q + IncStep;
            // Wrap happens exactly when the current pointer is all-ones.
            wrap_d = &bin_q;
        end

        // Gray is derived from the next binary value and registered, never
        // decoded from the bin_q flops on the output side.
        gray_d       = bin2gray(bin_d);
        remote_bin_d = gray2bin(i_gray_remote);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_q        <= InitBin;
            gray_q       <= InitGray;
            wrap_q       <= 1'b0;
            remote_bin_q <= '0;
        end else begin
            bin_q        <= bin_d;
            gray_q       <= gray_d;
            wrap_q       <= wrap_d;
            remote_bin_q <= remote_bin_d;
        end
    end

    assign o_bin        = bin_q;
    assign o_gray       = gray_q;
    assign o_wrap       = wrap_q;
    assign o_remote_bin = remote_bin_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Scoreboard bench for gray_ptr_counter. Four instances (WIDTH=4/INIT=0,
// WIDTH=4/INIT=5, WIDTH=2, WIDTH=8) share one stimulus stream, each taking the
// low bits of the load value and remote Gray value. The stimulus process pushes
// the expected state of every instance after each edge; a monitor pops and
// compares on the falling edge.

module tb_gray_ptr_counter;

    localparam int NINST = 4;
    localparam int W    [NINST] = '{4, 4, 2, 8};
    localparam int INITS[NINST] = '{0, 5, 0, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_bin = '0;
    logic [7:0] grem = '0;

    always #5 clk = ~clk;

    logic [3:0] b0, g0, r0;
    logic [3:0] b1, g1, r1;
    logic [1:0] b2, g2, r2;
    logic [7:0] b3, g3, r3;
    logic       w0, w1, w2, w3;

    gray_ptr_counter #(.WIDTH(4), .INIT(0)) u_w4 (
        .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_load(load),
        .i_load_bin(load_bin[3:0]), .i_gray_remote(grem[3:0]),
        .o_bin(b0), .o_gray(g0), .o_wrap(w0), .o_remote_bin(r0)
    );
    gray_ptr_counter #(.WIDTH(4), .INIT(5)) u_w4i5 (
        .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_load(load),
        .i_load_bin(load_bin[3:0]), .i_gray_remote(grem[3:0]),
        .o_bin(b1), .o_gray(g1), .o_wrap(w1), .o_remote_bin(r1)
    );
    gray_ptr_counter #(.WIDTH(2), .INIT(0)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_load(load),
        .i_load_bin(load_bin[1:0]), .i_gray_remote(grem[1:0]),
        .o_bin(b2), .o_gray(g2), .o_wrap(w2), .o_remote_bin(r2)
    );
    gray_ptr_counter #(.WIDTH(8), .INIT(0)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_load(load),
        .i_load_bin(load_bin), .i_gray_remote(grem),
        .o_bin(b3), .o_gray(g3), .o_wrap(w3), .o_remote_bin(r3)
    );

    typedef struct {
        int          idx;
        int unsigned bin;
        int unsigned gray;
        int unsigned rbin;
        bit          wrap;
        bit          inc_step;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state, one entry per instance.
    int unsigned m_bin[NINST];
    int unsigned m_rbin[NINST];

    // Decode by search: the binary value whose Gray code equals g.
    function automatic int unsigned ref_g2b(input int unsigned g, input int w);
        for (int unsigned b = 0; b < (32'd1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input int idx, input int unsigned act,
                         input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s[inst %0d] actual=%0h required=%0h at %0t",
                     name, idx, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit ld, input bit in, input logic [7:0] lb,
                        input logic [7:0] gr);
        exp_t e;
        @(negedge clk);
        #1;
        rst      = r;
        load     = ld;
        inc      = in;
        load_bin = lb;
        grem     = gr;
        for (int k = 0; k < NINST; k++) begin
            int unsigned mask;
            mask       = (32'd1 << W[k]) - 1;
            e.idx      = k;
            e.wrap     = 1'b0;
            e.inc_step = 1'b0;
            if (r) begin
                m_bin[k]  = INITS[k];
                m_rbin[k] = 0;
            end else begin
                if (ld) begin
                    m_bin[k] = lb & mask;
                end else if (in) begin
                    e.wrap     = (m_bin[k] == mask);
                    e.inc_step = 1'b1;
                    m_bin[k]   = (m_bin[k] + 1) % (mask + 1);
                end
                m_rbin[k] = ref_g2b(gr & mask, W[k]);
            end
            e.bin  = m_bin[k];
            e.gray = m_bin[k] ^ (m_bin[k] >> 1);
            e.rbin = m_rbin[k];
            sb_q.push_back(e);
        end
    endtask

    // Monitor: on every falling edge, compare the outputs produced by the
    // preceding rising edge against the queued expectations.
    int unsigned prev_gray[NINST];
    initial begin
        exp_t        e;
        int unsigned ab, ag, ar;
        bit          aw;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                unique case (e.idx)
                    0: begin ab = 32'(b0); ag = 32'(g0); ar = 32'(r0); aw = w0; end
                    1: begin ab = 32'(b1); ag = 32'(g1); ar = 32'(r1); aw = w1; end
                    2: begin ab = 32'(b2); ag = 32'(g2); ar = 32'(r2); aw = w2; end
                    default: begin ab = 32'(b3); ag = 32'(g3); ar = 32'(r3); aw = w3; end
                endcase
                check("o_bin", e.idx, ab, e.bin);
                check("o_gray", e.idx, ag, e.gray);
                check("o_wrap", e.idx, 32'(aw), 32'(e.wrap));
                check("o_remote_bin", e.idx, ar, e.rbin);
                if (e.inc_step) begin
                    check("gray_one_bit_step", e.idx, $countones(prev_gray[e.idx] ^ ag), 1);
                end
                prev_gray[e.idx] = ag;
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset for two cycles.
        step(1, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00);
        // Full cycle of 16 increments on the WIDTH=4 instance.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00, 8'h00);
        // Advance to 3, then load A with inc also high, then increment.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'hAA, 8'h00);
        step(0, 0, 1, 8'h00, 8'h00);
        // Remote decode sequence.
        step(0, 0, 0, 8'h00, 8'h0F);
        step(0, 0, 0, 8'h00, 8'h08);
        step(0, 0, 0, 8'h00, 8'h00);
        // Reset coincident with a wrap.
        step(0, 1, 0, 8'hFF, 8'h00);
        step(1, 0, 1, 8'h00, 8'h0F);
        // Hold for ten cycles.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 8'h00);
        // Full sweep wide enough to wrap the WIDTH=8 instance.
        for (int i = 0; i < 260; i++) step(0, 0, 1, 8'h00, 8'(i * 37));
        // Randomized traffic with occasional loads and resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
        end
        step(0, 0, 0, 8'h00, 8'h00);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
